alloc_arbiter: RTL and testbench
================================

Name: alloc_arbiter

Overview:
- Shares one block allocator (NUM_BLOCKS blocks, allocator-side ports en/request_size/o_addr/o_valid/o_err) between NUM_REQ requesters, e.g. RX/TX packet paths.
- Round-robin arbitration; exactly one outstanding allocator transaction at a time.
- Each allocator result is routed back to the requester that issued it.
- A watchdog converts a hung allocator into an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_BLOCKS, 32, allocator block count.
- NUM_BLOCKS_WIDTH, $clog2(NUM_BLOCKS), size/address width.
- TIMEOUT, 16, maximum WAIT cycles before forced error (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's resp_valid.
- req_size  in  NUM_REQ*NUM_BLOCKS_WIDTH  packed sizes; requester i uses bits [i*W +: W].
- resp_valid  out  NUM_REQ  one-hot, single-cycle response pulse.
- resp_addr  out  NUM_BLOCKS_WIDTH  allocated base block; shared by all requesters.
- resp_err  out  1  response is a failure; qualified by any resp_valid bit.
- busy  out  1  FSM not in IDLE.
- alloc_en  out  1  one-cycle allocator request strobe.
- alloc_size  out  NUM_BLOCKS_WIDTH  size presented with alloc_en.
- alloc_addr  in  NUM_BLOCKS_WIDTH  allocator o_addr.
- alloc_valid  in  1  allocator o_valid.
- alloc_err  in  1  allocator o_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0, FSM=IDLE, timeout counter 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transaction discards it silently; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Select the first asserted req_valid bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch grant index g and size; set last=g.
  - If the latched size = 0: set err, go to DONE; the allocator is not driven.
  - Otherwise go to ISSUE.
  - With no request pending, remain in IDLE.
- ISSUE:
  - alloc_en=1 for exactly this cycle, alloc_size=latched size.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - alloc_en=0; increment the counter each cycle.
  - alloc_err=1: latch err=1, go to DONE. err wins if alloc_valid is asserted in the same cycle.
  - Else alloc_valid=1: latch addr=alloc_addr and err=0, go to DONE.
  - Else counter reaches TIMEOUT-1: latch err=1, addr=0, go to DONE.
- DONE (one cycle):
  - resp_valid[g]=1, resp_addr=latched addr, resp_err=latched err.
  - Next state IDLE.
- Outside DONE: resp_valid=0; resp_addr and resp_err hold 0.
- Requester contract:
  - A requester deasserts req_valid at the clock edge ending its resp_valid cycle.
  - IDLE follows DONE, so no duplicate grant is possible.
- req_valid[g] dropping after the grant is ignored; the transaction completes and resp_valid[g] still pulses.
- req_size changes after latching are ignored.
- Latency (minimum allocator response of 1 cycle):
  - request seen in IDLE at cycle 0
  - alloc_en at cycle 1
  - alloc_valid at cycle 2
  - resp_valid at cycle 3
- Throughput: a new grant is possible at earliest cycle 4, i.e. one transaction per 4 cycles.
- Latency for size 0: resp at cycle 1.
- Spurious alloc_valid/alloc_err in IDLE, ISSUE or DONE is ignored.
- busy=1 in ISSUE, WAIT and DONE.

Test Plan:
- Single request:
  - Stimulus: req_valid=0001, size 3; allocator returns addr 5 one cycle after alloc_en.
  - Required: alloc_en pulses once with alloc_size=3.
  - Required: resp_valid=0001, resp_addr=5, resp_err=0, exactly 3 cycles after req_valid was first sampled.
- Round-robin fairness:
  - Stimulus: all four req_valid held high continuously, each re-raised immediately after its response.
  - Required: grant order 0,1,2,3,0,1,...; no requester receives two grants before the others receive one.
- Allocator error:
  - Stimulus: requester 2, size 31; allocator asserts alloc_err together with alloc_valid.
  - Required: resp_valid=0100, resp_err=1.
- Timeout:
  - Stimulus: allocator never responds, TIMEOUT=16.
  - Required: resp_valid pulses 16 cycles after alloc_en with resp_err=1 and resp_addr=0; the next request is then serviced normally.
- Zero size and abandoned request:
  - Stimulus A: requester 1 size 0.
  - Required A: resp_valid=0010, resp_err=1 one cycle later; alloc_en never asserts.
  - Stimulus B: requester 3 drops req_valid while the FSM is in WAIT.
  - Required B: resp_valid=1000 still pulses.
- Async reset mid-WAIT:
  - Stimulus: assert rst=0 for 2 cycles during WAIT.
  - Required: all outputs 0 immediately, with no clock edge needed.
  - Required after release: requester 0 wins simultaneous requests from 0 and 2.

Source files
------------

// File: rtl/alloc_arbiter_if.sv
// alloc_arbiter_if: requester and allocator bus bundle for alloc_arbiter
// Requester side: req_valid/req_size in, resp_valid/resp_addr/resp_err/busy out.
// Allocator side: alloc_en/alloc_size out, alloc_addr/alloc_valid/alloc_err in.
// The slave modport is the arbiter's view; master is the requesters plus allocator.
interface alloc_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 5
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_size;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W-1:0]         resp_addr;
  logic                 resp_err;
  logic                 busy;
  logic                 alloc_en;
  logic [W-1:0]         alloc_size;
  logic [W-1:0]         alloc_addr;
  logic                 alloc_valid;
  logic                 alloc_err;
  modport slave (
    input  req_valid, req_size, alloc_addr, alloc_valid, alloc_err,
    output resp_valid, resp_addr, resp_err, busy, alloc_en, alloc_size
  );
  modport master (
    output req_valid, req_size, alloc_addr, alloc_valid, alloc_err,
    input  resp_valid, resp_addr, resp_err, busy, alloc_en, alloc_size
  );
endinterface

// File: rtl/alloc_arbiter.sv
// alloc_arbiter: round-robin sharing of one block allocator among NUM_REQ requesters
// clk        : rising-edge clock
// rst        : asynchronous active-low reset
// bus.slave  : requester handshake (req_valid/req_size -> resp_valid/resp_addr/resp_err/busy)
//              and allocator handshake (alloc_en/alloc_size -> alloc_addr/alloc_valid/alloc_err)
module alloc_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int NUM_BLOCKS       = 32,
  parameter int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS),
  parameter int TIMEOUT          = 16
) (
  input  logic           clk,
  input  logic           rst,
  alloc_arbiter_if.slave bus
);
  localparam int W  = NUM_BLOCKS_WIDTH;
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [W-1:0]    size_q, size_d;
  logic [W-1:0]    addr_q, addr_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found;
  logic [GW-1:0]   pick, idx;
  logic [W-1:0]    sel_size;
  // Walk downwards from last+NUM_REQ to last+1 so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == pick) sel_size = bus.req_size[i*W +: W];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      size_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    size_d  = size_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        last_d  = pick;
        size_d  = sel_size;
        addr_d  = '0;
        err_d   = sel_size == '0;
        state_d = sel_size == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.alloc_err) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.alloc_valid) begin
          addr_d  = bus.alloc_addr;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 2)) begin
          // Counter is about to reach TIMEOUT-1: give up on the allocator.
          addr_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy       = state_q != IDLE;
  assign bus.alloc_en   = state_q == ISSUE;
  assign bus.alloc_size = state_q == ISSUE ? size_q : '0;
  assign bus.resp_valid = state_q == DONE ? NUM_REQ'(1) << grant_q : '0;
  assign bus.resp_addr  = state_q == DONE ? addr_q : '0;
  assign bus.resp_err   = state_q == DONE && err_q;
endmodule

// File: tb/tb_alloc_arbiter.sv
// tb_alloc_arbiter: directed self-checking bench for alloc_arbiter
module tb_alloc_arbiter;
  localparam int N = 4;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int en_count = 0;
  alloc_arbiter_if #(.NUM_REQ(N), .W(W)) bus();
  alloc_arbiter #(.NUM_REQ(N), .NUM_BLOCKS(32), .NUM_BLOCKS_WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.alloc_en) en_count <= en_count + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_size = '0;
    bus.alloc_addr = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_err = 1'b0;
  endtask
  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
    n_chk++; if (bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_resp_valid: got %0h want 0", bus.resp_valid); end
    n_chk++; if (bus.alloc_en !== 1'b0) begin n_fail++; $display("FAIL reset_alloc_en: got %0h want 0", bus.alloc_en); end
    n_chk++; if (bus.resp_addr !== 5'd0 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got addr %0h err %0h want 0 0", bus.resp_addr, bus.resp_err); end
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_round_robin();
    logic [N-1:0] exp_v;
    bus.req_valid = 4'hf;
    for (int i = 0; i < N; i++) bus.req_size[i*W +: W] = W'(i + 1);
    for (int t = 0; t < 8; t++) begin
      exp_v = 4'b1 << (t % N);
      @(negedge clk);
      n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== W'(t % N + 1)) begin n_fail++; $display("FAIL rr_issue%0d: got en %0h size %0d want 1 %0d", t, bus.alloc_en, bus.alloc_size, t % N + 1); end
      @(negedge clk);
      bus.alloc_valid = 1'b1;
      bus.alloc_addr = W'(t + 10);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      n_chk++; if (bus.resp_valid !== exp_v || bus.resp_addr !== W'(t + 10) || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rr_resp%0d: got v %0h addr %0d err %0h want %0h %0d 0", t, bus.resp_valid, bus.resp_addr, bus.resp_err, exp_v, t + 10); end
      @(negedge clk);
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got busy %0h want 0", t, bus.busy); end
    end
    idle_inputs();
    @(negedge clk);
  endtask
  task automatic test_single();
    int e0;
    e0 = en_count;
    bus.req_valid = 4'b0001;
    bus.req_size[0 +: W] = 5'd3;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== 5'd3) begin n_fail++; $display("FAIL single_issue: got en %0h size %0d want 1 3", bus.alloc_en, bus.alloc_size); end
    n_chk++; if (bus.busy !== 1'b1 || bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL single_busy: got busy %0h v %0h want 1 0", bus.busy, bus.resp_valid); end
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b0 || bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL single_wait: got en %0h v %0h want 0 0", bus.alloc_en, bus.resp_valid); end
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd5;
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    n_chk++; if (bus.resp_valid !== 4'b0001 || bus.resp_addr !== 5'd5 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL single_resp: got v %0h addr %0d err %0h want 1 5 0", bus.resp_valid, bus.resp_addr, bus.resp_err); end
    bus.req_valid = '0;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'h0 || bus.resp_addr !== 5'd0) begin n_fail++; $display("FAIL single_after: got v %0h addr %0d want 0 0", bus.resp_valid, bus.resp_addr); end
    n_chk++; if (en_count - e0 !== 1) begin n_fail++; $display("FAIL single_en_count: got %0d want 1", en_count - e0); end
  endtask
  task automatic test_alloc_err();
    bus.req_valid = 4'b0100;
    bus.req_size[2*W +: W] = 5'd31;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== 5'd31) begin n_fail++; $display("FAIL err_issue: got en %0h size %0d want 1 31", bus.alloc_en, bus.alloc_size); end
    @(negedge clk);
    bus.alloc_err = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd7;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL err_resp: got v %0h err %0h want 4 1", bus.resp_valid, bus.resp_err); end
    idle_inputs();
    @(negedge clk);
  endtask
  task automatic test_timeout();
    int cyc;
    bus.req_valid = 4'b0001;
    bus.req_size[0 +: W] = 5'd4;
    bus.alloc_addr = 5'h1f;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1) begin n_fail++; $display("FAIL to_issue: got en %0h want 1", bus.alloc_en); end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.resp_valid === 4'h0 && cyc < 40);
    n_chk++; if (cyc !== 16) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 16", cyc); end
    n_chk++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b1 || bus.resp_addr !== 5'd0) begin n_fail++; $display("FAIL to_resp: got v %0h err %0h addr %0d want 1 1 0", bus.resp_valid, bus.resp_err, bus.resp_addr); end
    idle_inputs();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_size[1*W +: W] = 5'd2;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== 5'd2) begin n_fail++; $display("FAIL to_next_issue: got en %0h size %0d want 1 2", bus.alloc_en, bus.alloc_size); end
    @(negedge clk);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd9;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'b0010 || bus.resp_addr !== 5'd9 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL to_next_resp: got v %0h addr %0d err %0h want 2 9 0", bus.resp_valid, bus.resp_addr, bus.resp_err); end
    idle_inputs();
    @(negedge clk);
  endtask
  task automatic test_zero_abandon();
    int e0;
    e0 = en_count;
    bus.req_valid = 4'b0010;
    bus.req_size[1*W +: W] = 5'd0;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'b0010 || bus.resp_err !== 1'b1 || bus.alloc_en !== 1'b0) begin n_fail++; $display("FAIL zero_resp: got v %0h err %0h en %0h want 2 1 0", bus.resp_valid, bus.resp_err, bus.alloc_en); end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (en_count !== e0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_no_alloc: got en pulses %0d busy %0h want 0 0", en_count - e0, bus.busy); end
    bus.req_valid = 4'b1000;
    bus.req_size[3*W +: W] = 5'd6;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== 5'd6) begin n_fail++; $display("FAIL abandon_issue: got en %0h size %0d want 1 6", bus.alloc_en, bus.alloc_size); end
    bus.alloc_err = 1'b1;
    bus.alloc_valid = 1'b1;
    @(negedge clk);
    bus.alloc_err = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.req_valid = '0;
    bus.req_size = '0;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1 || bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL abandon_wait: got busy %0h v %0h want 1 0", bus.busy, bus.resp_valid); end
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd12;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'b1000 || bus.resp_addr !== 5'd12 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL abandon_resp: got v %0h addr %0d err %0h want 8 12 0", bus.resp_valid, bus.resp_addr, bus.resp_err); end
    idle_inputs();
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    bus.req_valid = 4'b0001;
    bus.req_size[0 +: W] = 5'd7;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.alloc_en !== 1'b0 || bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL areset_immediate: got busy %0h en %0h v %0h want 0 0 0", bus.busy, bus.alloc_en, bus.resp_valid); end
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd3;
    bus.req_valid = 4'b0101;
    bus.req_size[0 +: W] = 5'd2;
    bus.req_size[2*W +: W] = 5'd3;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0 || bus.resp_valid !== 4'h0) begin n_fail++; $display("FAIL areset_hold: got busy %0h v %0h want 0 0", bus.busy, bus.resp_valid); end
    bus.alloc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.alloc_en !== 1'b1 || bus.alloc_size !== 5'd2) begin n_fail++; $display("FAIL areset_prio_issue: got en %0h size %0d want 1 2", bus.alloc_en, bus.alloc_size); end
    @(negedge clk);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr = 5'd1;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 4'b0001 || bus.resp_addr !== 5'd1) begin n_fail++; $display("FAIL areset_prio_resp: got v %0h addr %0d want 1 1", bus.resp_valid, bus.resp_addr); end
    idle_inputs();
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_alloc_err();
    test_timeout();
    test_zero_abandon();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
